// File: rtl/pmod_cls_pkg.sv
// Shared types and constants for the PMOD CLS command sequencer.
// Defining PMOD_CLS_DISPLAY_SETUP_EN adds the post-reset display setup state.
package pmod_cls_pkg;

`ifdef PMOD_CLS_DISPLAY_SETUP_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_SETUP = 2'd2
  } t_cls_seq_state;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1
  } t_cls_seq_state;
`endif

  typedef enum logic [1:0] {
    CMD_CLEAR = 2'd0,
    CMD_LINE1 = 2'd1,
    CMD_LINE2 = 2'd2,
    CMD_SETUP = 2'd3
  } t_cls_cmd;

  localparam logic [7:0] ESC_BYTE      = 8'h1B;
  localparam logic [7:0] LBRACKET_BYTE = 8'h5B;
  localparam logic [7:0] SPACE_BYTE    = 8'h20;
  localparam logic [7:0] PRINT_MIN     = 8'h20;
  localparam logic [7:0] PRINT_MAX     = 8'h7E;

  localparam logic [4:0] LEN_CLEAR = 5'd3;
  localparam logic [4:0] LEN_LINE  = 5'd22;
  localparam logic [4:0] LEN_SETUP = 5'd8;

  function automatic logic [4:0] last_index(input t_cls_cmd cmd);
    case (cmd)
      CMD_CLEAR: return LEN_CLEAR - 5'd1;
      CMD_SETUP: return LEN_SETUP - 5'd1;
      default:   return LEN_LINE - 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/pmod_cls_cmd_sequencer_byte_select.sv
// Combinational map from (command, byte index, latched text) to the outgoing
// escape-sequence byte; non-printable text characters become spaces.
module pmod_cls_byte_select
  import pmod_cls_pkg::*;
(
  input  logic [1:0]   cmd,
  input  logic [4:0]   index,
  input  logic [127:0] text,
  output logic [7:0]   tx_byte
);

  t_cls_cmd   cmd_e;
  logic [3:0] char_pos;
  logic [7:0] raw_char;
  logic [7:0] clean_char;

  assign cmd_e = t_cls_cmd'(cmd);

  // Text occupies indices 6..21, so the low nibble of (index - 6) is the char slot.
  assign char_pos   = index[3:0] - 4'd6;
  assign raw_char   = text[{~char_pos, 3'b000} +: 8];
  assign clean_char = (raw_char < PRINT_MIN || raw_char > PRINT_MAX) ? SPACE_BYTE : raw_char;

  always_comb begin
    // NOTE: default first so every path assigns tx_byte and no latch is inferred.
    tx_byte = 8'h00;
    case (cmd_e)
      CMD_CLEAR: begin
        case (index)
          5'd0:    tx_byte = ESC_BYTE;
          5'd1:    tx_byte = LBRACKET_BYTE;
          5'd2:    tx_byte = 8'h6A;
          default: tx_byte = 8'h00;
        endcase
      end
      CMD_LINE1, CMD_LINE2: begin
        case (index)
          5'd0:    tx_byte = ESC_BYTE;
          5'd1:    tx_byte = LBRACKET_BYTE;
          5'd2:    tx_byte = (cmd_e == CMD_LINE1) ? 8'h30 : 8'h31;
          5'd3:    tx_byte = 8'h3B;
          5'd4:    tx_byte = 8'h30;
          5'd5:    tx_byte = 8'h48;
          default: tx_byte = clean_char;
        endcase
      end
      CMD_SETUP: begin
        case (index[2:0])
          3'd0:    tx_byte = ESC_BYTE;
          3'd1:    tx_byte = LBRACKET_BYTE;
          3'd2:    tx_byte = 8'h30;
          3'd3:    tx_byte = 8'h63;
          3'd4:    tx_byte = ESC_BYTE;
          3'd5:    tx_byte = LBRACKET_BYTE;
          3'd6:    tx_byte = 8'h30;
          default: tx_byte = 8'h68;
        endcase
      end
      default: tx_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/pmod_cls_cmd_sequencer.sv
// Turns clear / line1 / line2 requests into PMOD CLS escape byte streams on a
// valid/ready byte port. Optional macro: PMOD_CLS_DISPLAY_SETUP_EN.
module pmod_cls_cmd_sequencer
  import pmod_cls_pkg::*;
#(
  parameter int parm_fast_simulation = 0
) (
  input  logic         i_clk_20mhz,
  input  logic         i_rst_20mhz,
  input  logic         i_ce_2_5mhz,
  input  logic         i_lcd_wr_clear_display,
  input  logic         i_lcd_wr_text_line1,
  input  logic         i_lcd_wr_text_line2,
  input  logic [127:0] i_dat_ascii_line1,
  input  logic [127:0] i_dat_ascii_line2,
  output logic         o_lcd_command_ready,
  output logic [7:0]   o_tx_data,
  output logic         o_tx_valid,
  input  logic         i_tx_ready
);

`ifdef PMOD_CLS_DISPLAY_SETUP_EN
  localparam t_cls_seq_state STATE_AT_RESET = ST_SETUP;
  localparam t_cls_cmd       CMD_AT_RESET   = CMD_SETUP;
`else
  localparam t_cls_seq_state STATE_AT_RESET = ST_IDLE;
  localparam t_cls_cmd       CMD_AT_RESET   = CMD_CLEAR;
`endif

  t_cls_seq_state state, state_next;
  t_cls_cmd       cmd, cmd_next;
  logic [4:0]     index, index_next;
  logic [127:0]   text;
  logic           accept;
  logic           transfer;
  logic [7:0]     sel_byte;

  // Behaviour is identical for fast and normal simulation builds.
  if (parm_fast_simulation != 0) begin : g_fast_sim
  end

  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      state <= STATE_AT_RESET;
      cmd   <= CMD_AT_RESET;
      index <= 5'd0;
    end else if (i_ce_2_5mhz) begin
      state <= state_next;
      cmd   <= cmd_next;
      index <= index_next;
    end
  end

  // NOTE: text is only read after an accept has loaded it, so it carries no reset.
  always_ff @(posedge i_clk_20mhz) begin
    if (i_ce_2_5mhz && accept) begin
      text <= i_lcd_wr_text_line1 ? i_dat_ascii_line1 : i_dat_ascii_line2;
    end
  end

  always_comb begin
    state_next = state;
    cmd_next   = cmd;
    index_next = index;
    accept     = 1'b0;
    transfer   = (state != ST_IDLE) && i_tx_ready;
    case (state)
      ST_IDLE: begin
        if (i_lcd_wr_clear_display || i_lcd_wr_text_line1 || i_lcd_wr_text_line2) begin
          accept     = 1'b1;
          state_next = ST_SEND;
          index_next = 5'd0;
          if (i_lcd_wr_clear_display)   cmd_next = CMD_CLEAR;
          else if (i_lcd_wr_text_line1) cmd_next = CMD_LINE1;
          else                          cmd_next = CMD_LINE2;
        end
      end
      // Sending and setup share the same byte-stepping behaviour.
      default: begin
        if (transfer) begin
          if (index == last_index(cmd)) begin
            state_next = ST_IDLE;
            index_next = 5'd0;
          end else begin
            index_next = index + 5'd1;
          end
        end
      end
    endcase
  end

  pmod_cls_byte_select u_byte_select (
    .cmd     (cmd),
    .index   (index),
    .text    (text),
    .tx_byte (sel_byte)
  );

  assign o_tx_valid          = (state != ST_IDLE);
  assign o_tx_data           = o_tx_valid ? sel_byte : 8'h00;
  assign o_lcd_command_ready = (state == ST_IDLE);

endmodule

// File: tb/tb_pmod_cls_cmd_sequencer.sv
// Directed self-checking bench for pmod_cls_cmd_sequencer; honours
// PMOD_CLS_DISPLAY_SETUP_EN when it is defined for the build.
module tb_pmod_cls_cmd_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         ce;
  logic         req_clear;
  logic         req_line1;
  logic         req_line2;
  logic [127:0] line1;
  logic [127:0] line2;
  logic         tx_ready;
  logic         cmd_ready;
  logic [7:0]   tx_data;
  logic         tx_valid;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         busy_ce;
  int         stable_err;
  bit         timed_out;
  logic       end_valid;
  logic       end_ready;

`ifdef PMOD_CLS_DISPLAY_SETUP_EN
  localparam logic READY_AFTER_RESET = 1'b0;
`else
  localparam logic READY_AFTER_RESET = 1'b1;
`endif

  pmod_cls_cmd_sequencer #(.parm_fast_simulation(0)) dut (
    .i_clk_20mhz            (clk),
    .i_rst_20mhz            (rst),
    .i_ce_2_5mhz            (ce),
    .i_lcd_wr_clear_display (req_clear),
    .i_lcd_wr_text_line1    (req_line1),
    .i_lcd_wr_text_line2    (req_line2),
    .i_dat_ascii_line1      (line1),
    .i_dat_ascii_line2      (line2),
    .o_lcd_command_ready    (cmd_ready),
    .o_tx_data              (tx_data),
    .o_tx_valid             (tx_valid),
    .i_tx_ready             (tx_ready)
  );

  always #25 clk = ~clk;

  int ce_div = 0;
  always @(posedge clk) begin
    #1;
    ce_div = (ce_div + 1) % 4;
    ce = (ce_div == 0);
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic step_ce();
    do @(posedge clk); while (ce !== 1'b1);
    #5;
  endtask

  // Runs CE periods, logging every byte that transfers, until n_exp bytes are seen.
  task automatic collect(input int n_exp, input bit toggle, input int change_at);
    bit         prev_pending;
    logic [7:0] prev_data;
    got_q.delete();
    busy_ce      = 0;
    stable_err   = 0;
    timed_out    = 1'b1;
    prev_pending = 1'b0;
    prev_data    = 8'h00;
    for (int k = 0; k < 400; k++) begin
      tx_ready = toggle ? (k % 2 == 1) : 1'b1;
      if (k == change_at) line1 = "????????????????";
      if (cmd_ready !== 1'b1) busy_ce++;
      if (prev_pending && (tx_valid !== 1'b1 || tx_data !== prev_data)) stable_err++;
      prev_pending = (tx_valid === 1'b1) && !tx_ready;
      prev_data    = tx_data;
      if (tx_valid === 1'b1 && tx_ready) got_q.push_back(tx_data);
      step_ce();
      if (got_q.size() == n_exp) begin
        timed_out = 1'b0;
        break;
      end
    end
    end_valid = tx_valid;
    end_ready = cmd_ready;
    tx_ready  = 1'b1;
  endtask

  task automatic load_line_exp(input logic [7:0] row, input logic [127:0] txt);
    exp_q = '{8'h1B, 8'h5B, row, 8'h3B, 8'h30, 8'h48};
    for (int k = 0; k < 16; k++) exp_q.push_back(txt[127 - 8*k -: 8]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #5;
    total_cnt++;
    if (tx_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", tx_valid);
    else pass_cnt++;
    total_cnt++;
    if (tx_data !== 8'h00) $display("FAIL reset_data: got %h want 00", tx_data);
    else pass_cnt++;
    total_cnt++;
    if (cmd_ready !== READY_AFTER_RESET)
      $display("FAIL reset_ready: got %b want %b", cmd_ready, READY_AFTER_RESET);
    else pass_cnt++;
    rst = 1'b0;
  endtask

`ifdef PMOD_CLS_DISPLAY_SETUP_EN
  task automatic test_setup();
    logic [7:0] act;
    req_clear = 1'b1;
    collect(8, 1'b0, -1);
    req_clear = 1'b0;
    exp_q = '{8'h1B, 8'h5B, 8'h30, 8'h63, 8'h1B, 8'h5B, 8'h30, 8'h68};
    total_cnt++;
    if (timed_out || got_q.size() != 8) $display("FAIL setup_len: got %0d want 8", got_q.size());
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      act = (i < int'(got_q.size())) ? got_q[i] : 8'hxx;
      total_cnt++;
      if (act !== exp_q[i]) $display("FAIL setup_byte%0d: got %h want %h", i, act, exp_q[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (busy_ce != 8) $display("FAIL setup_busy: got %0d want 8", busy_ce);
    else pass_cnt++;
    total_cnt++;
    if (end_ready !== 1'b1) $display("FAIL setup_end_ready: got %b want 1", end_ready);
    else pass_cnt++;
    step_ce();
    total_cnt++;
    if (tx_valid !== 1'b0) $display("FAIL setup_clear_ignored: got valid %b want 0", tx_valid);
    else pass_cnt++;
  endtask
`endif

  task automatic test_clear();
    logic [7:0] act;
    total_cnt++;
    if (cmd_ready !== 1'b1) $display("FAIL clear_pre_ready: got %b want 1", cmd_ready);
    else pass_cnt++;
    req_clear = 1'b1;
    step_ce();
    req_clear = 1'b0;
    collect(3, 1'b0, -1);
    exp_q = '{8'h1B, 8'h5B, 8'h6A};
    total_cnt++;
    if (timed_out || got_q.size() != 3) $display("FAIL clear_len: got %0d want 3", got_q.size());
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      act = (i < int'(got_q.size())) ? got_q[i] : 8'hxx;
      total_cnt++;
      if (act !== exp_q[i]) $display("FAIL clear_byte%0d: got %h want %h", i, act, exp_q[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (busy_ce != 3) $display("FAIL clear_busy: got %0d want 3", busy_ce);
    else pass_cnt++;
    total_cnt++;
    if (end_valid !== 1'b0 || end_ready !== 1'b1)
      $display("FAIL clear_end: got valid %b ready %b want valid 0 ready 1", end_valid, end_ready);
    else pass_cnt++;
  endtask

  task automatic test_line1();
    logic [127:0] txt;
    logic [7:0]   act;
    txt   = "ACCEL X: +0.012g";
    line1 = txt;
    req_line1 = 1'b1;
    step_ce();
    req_line1 = 1'b0;
    collect(22, 1'b0, 8);
    load_line_exp(8'h30, txt);
    total_cnt++;
    if (timed_out || got_q.size() != 22) $display("FAIL line1_len: got %0d want 22", got_q.size());
    else pass_cnt++;
    for (int i = 0; i < 22; i++) begin
      act = (i < int'(got_q.size())) ? got_q[i] : 8'hxx;
      total_cnt++;
      if (act !== exp_q[i]) $display("FAIL line1_byte%0d: got %h want %h", i, act, exp_q[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (busy_ce != 22) $display("FAIL line1_busy: got %0d want 22", busy_ce);
    else pass_cnt++;
    total_cnt++;
    if (end_valid !== 1'b0 || end_ready !== 1'b1)
      $display("FAIL line1_end: got valid %b ready %b want valid 0 ready 1", end_valid, end_ready);
    else pass_cnt++;
  endtask

  task automatic test_priority();
    logic [7:0] act;
    line2 = "SHOULD NOT SHOW!";
    req_clear = 1'b1;
    req_line2 = 1'b1;
    step_ce();
    req_clear = 1'b0;
    req_line2 = 1'b0;
    collect(3, 1'b0, -1);
    exp_q = '{8'h1B, 8'h5B, 8'h6A};
    for (int i = 0; i < 3; i++) begin
      act = (i < int'(got_q.size())) ? got_q[i] : 8'hxx;
      total_cnt++;
      if (act !== exp_q[i]) $display("FAIL prio_byte%0d: got %h want %h", i, act, exp_q[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (timed_out || end_ready !== 1'b1) $display("FAIL prio_end_ready: got %b want 1", end_ready);
    else pass_cnt++;
    step_ce();
    step_ce();
    total_cnt++;
    if (tx_valid !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL prio_line2_dropped: got valid %b ready %b want valid 0 ready 1", tx_valid, cmd_ready);
    else pass_cnt++;
  endtask

  task automatic test_ready_toggle();
    logic [127:0] exp_txt;
    logic [127:0] in_txt;
    logic [7:0]   act;
    exp_txt = "TEMP 23.5C HIGH!";
    in_txt  = exp_txt;
    in_txt[127 - 8*4 -: 8] = 8'h07;
    line2 = in_txt;
    req_line2 = 1'b1;
    step_ce();
    req_line2 = 1'b0;
    collect(22, 1'b1, -1);
    load_line_exp(8'h31, exp_txt);
    total_cnt++;
    if (timed_out || got_q.size() != 22) $display("FAIL toggle_len: got %0d want 22", got_q.size());
    else pass_cnt++;
    for (int i = 0; i < 22; i++) begin
      act = (i < int'(got_q.size())) ? got_q[i] : 8'hxx;
      total_cnt++;
      if (act !== exp_q[i]) $display("FAIL toggle_byte%0d: got %h want %h", i, act, exp_q[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (stable_err != 0) $display("FAIL toggle_stall_stable: got %0d changes want 0", stable_err);
    else pass_cnt++;
    total_cnt++;
    if (end_valid !== 1'b0 || end_ready !== 1'b1)
      $display("FAIL toggle_end: got valid %b ready %b want valid 0 ready 1", end_valid, end_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [127:0] txt;
    logic [7:0]   act;
    txt   = "ACCEL X: +0.012g";
    line1 = txt;
    req_line1 = 1'b1;
    step_ce();
    req_line1 = 1'b0;
    tx_ready = 1'b1;
    for (int k = 0; k < 10; k++) step_ce();
    total_cnt++;
    if (tx_data !== 8'h4C) $display("FAIL midrst_index10: got %h want 4c", tx_data);
    else pass_cnt++;
    rst = 1'b1;
    @(posedge clk);
    #5;
    total_cnt++;
    if (tx_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", tx_valid);
    else pass_cnt++;
    total_cnt++;
    if (cmd_ready !== READY_AFTER_RESET)
      $display("FAIL midrst_ready: got %b want %b", cmd_ready, READY_AFTER_RESET);
    else pass_cnt++;
    rst = 1'b0;
`ifdef PMOD_CLS_DISPLAY_SETUP_EN
    collect(8, 1'b0, -1);
`endif
    req_line1 = 1'b1;
    step_ce();
    req_line1 = 1'b0;
    collect(22, 1'b0, -1);
    load_line_exp(8'h30, txt);
    total_cnt++;
    if (timed_out || got_q.size() != 22) $display("FAIL midrst_len: got %0d want 22", got_q.size());
    else pass_cnt++;
    for (int i = 0; i < 22; i++) begin
      act = (i < int'(got_q.size())) ? got_q[i] : 8'hxx;
      total_cnt++;
      if (act !== exp_q[i]) $display("FAIL midrst_byte%0d: got %h want %h", i, act, exp_q[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    req_clear = 1'b1;
    step_ce();
    req_clear = 1'b0;
    collect(3, 1'b0, -1);
    total_cnt++;
    if (timed_out || end_ready !== 1'b1) $display("FAIL b2b_first_done: got ready %b want 1", end_ready);
    else pass_cnt++;
    req_clear = 1'b1;
    step_ce();
    req_clear = 1'b0;
    total_cnt++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h1B || cmd_ready !== 1'b0)
      $display("FAIL b2b_accept: got valid %b data %h ready %b want valid 1 data 1b ready 0",
               tx_valid, tx_data, cmd_ready);
    else pass_cnt++;
    collect(3, 1'b0, -1);
    total_cnt++;
    if (timed_out || got_q.size() != 3 || end_ready !== 1'b1)
      $display("FAIL b2b_second: got %0d bytes ready %b want 3 bytes ready 1", got_q.size(), end_ready);
    else pass_cnt++;
  endtask

  initial begin
    rst       = 1'b1;
    ce        = 1'b0;
    req_clear = 1'b0;
    req_line1 = 1'b0;
    req_line2 = 1'b0;
    line1     = '0;
    line2     = '0;
    tx_ready  = 1'b1;

    test_reset();
`ifdef PMOD_CLS_DISPLAY_SETUP_EN
    test_setup();
`endif
    test_clear();
    test_line1();
    test_priority();
    test_ready_toggle();
    test_reset_mid();
    test_back_to_back();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
